// File: rtl/pc_fetch_ctrl.sv
// ============================================================================
//  Module   : pc_fetch_ctrl
//  Purpose  : PC register, IDLE/FETCH/HALTED sequencer, imem req/ack handshake
//             and next-PC selection for the single-cycle CPU.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic        Halt,
  output logic        ImemReq,
  input  logic        ImemAck,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [15:0] Imm,
  input  logic        Jump,
  input  logic [25:0] JumpTarget,
  input  logic        JumpReg,
  input  logic [31:0] RegData,
  output logic [31:0] PCAddr,
  output logic [31:0] NextPC,
  output logic        PCWrite,
  output logic        Halted,
  output logic        AlignErr,
  output logic [31:0] InstrCount
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [31:0] c_count_max = 32'hFFFF_FFFF;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_count;
  logic [31:0] w_pc4;
  logic [31:0] w_br_off;
  logic        w_commit;

  assign w_pc4    = r_pc + 32'd4;
  assign w_br_off = {{14{Imm[15]}}, Imm, 2'b00};

  always_comb begin
    NextPC = w_pc4;
    if (JumpReg)
      NextPC = {RegData[31:2], 2'b00};
    else if (Jump)
      NextPC = {w_pc4[31:28], JumpTarget, 2'b00};
    else if (Branch && Zero)
      NextPC = w_pc4 + w_br_off;
  end

  // Handshake and status outputs decode straight from the registered state.
  assign w_commit   = (r_state == FETCH) && ImemAck;
  assign ImemReq    = (r_state == FETCH);
  assign Halted     = (r_state == HALTED);
  assign PCWrite    = w_commit;
  assign AlignErr   = w_commit && JumpReg && (RegData[1:0] != 2'b00);
  assign PCAddr     = r_pc;
  assign InstrCount = r_count;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_ADDR;
      r_count <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Run)
            r_state <= FETCH;
        end
        FETCH: begin
          if (ImemAck) begin
            r_pc <= NextPC;
            if (r_count != c_count_max)
              r_count <= r_count + 32'd1;
            if (Halt)
              r_state <= HALTED;
          end
        end
        HALTED: begin
          if (Run && !Halt)
            r_state <= FETCH;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch sequencer for the program counter of the single-cycle CPU. It owns the PC register, runs the start/halt state machine, and holds an instruction-memory request/acknowledge handshake. At each acknowledged fetch it commits the next PC, selected from sequential, branch, jump, or jump-register sources. It sits between the control unit / ALU outputs and the instruction memory, and feeds the current PC to the rest of the datapath.

## Interface

- RESET_ADDR, 32'h0000_0000, PC value loaded at reset.
- Clk  in  1  system clock, rising-edge.
- Reset  in  1  asynchronous, active-low; clock Clk.
- Run  in  1  level; starts or resumes fetching from IDLE or HALTED.
- Halt  in  1  level; sampled only at commit; stops after the committing instruction.
- ImemReq  out  1  fetch request for the instruction at PCAddr.
- ImemAck  in  1  instruction memory has returned the instruction at PCAddr this cycle; qualifies commit.
- Branch  in  1  current instruction is a conditional branch.
- Zero  in  1  ALU zero flag; branch taken when Branch&Zero.
- Imm  in  16  branch offset in words, signed.
- Jump  in  1  current instruction is a J-type jump.
- JumpTarget  in  26  jump word index.
- JumpReg  in  1  current instruction is a register jump.
- RegData  in  32  register operand for a register jump.
- PCAddr  out  32  current PC.
- NextPC  out  32  combinational next-PC value.
- PCWrite  out  1  one-cycle pulse on each commit.
- Halted  out  1  high while in HALTED.
- AlignErr  out  1  one-cycle pulse when a register-jump target was misaligned.
- InstrCount  out  32  number of committed instructions.

## Operation

- States: IDLE (reset state), FETCH, HALTED. Encoded in a registered state variable.
- IDLE: ImemReq=0. Run=1 moves the block to FETCH. Halt is ignored in IDLE.
- FETCH: ImemReq=1. A cycle with ImemAck=1 is a commit. Without ImemAck, PCAddr and all redirect decisions hold.
- Commit actions:
  - PCAddr <= NextPC.
  - PCWrite=1 for that cycle.
  - InstrCount increments and saturates at 32'hFFFF_FFFF.
  - If Halt=1, the next state is HALTED; otherwise FETCH.
- HALTED: ImemReq=0, Halted=1.
  - Run=1 with Halt=0 returns to FETCH at the unchanged PCAddr.
  - Run=1 with Halt=1 stays HALTED.
- NextPC priority, with PC4 = PCAddr+4:
  - JumpReg: {RegData[31:2],2'b00}.
  - Jump: {PC4[31:28],JumpTarget,2'b00}.
  - Branch&Zero: PC4 + (sign-extended Imm << 2).
  - Otherwise: PC4.
- Width and arithmetic rules:
  - All additions are 32-bit, modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
  - A negative Imm wraps the same way.
- AlignErr pulses on a commit where JumpReg=1 and RegData[1:0]!=0. The target is still committed with its low bits forced to zero.
- Redirect inputs are only meaningful on the commit cycle; values on other cycles are ignored.

## Timing

- Reset (asynchronous, immediate, in any state, including mid-handshake):
  - state=IDLE, PCAddr=RESET_ADDR, ImemReq=0, PCWrite=0, Halted=0, AlignErr=0, InstrCount=0.
  - An ImemAck arriving during or after reset in IDLE is ignored.
- Run high on edge N in IDLE: ImemReq=1 from cycle N+1.
- Fetch latency: commit occurs on the first rising edge with ImemAck=1 while in FETCH; PCAddr shows the new value after that edge.
- Throughput: ImemAck held high gives one commit per cycle; ImemReq stays high between back-to-back commits.
- PCWrite, AlignErr, ImemReq and Halted are decoded from the registered state plus the ImemAck/redirect inputs of the current cycle.
- Halt on a commit edge: that commit completes, state is HALTED after the edge, and ImemReq=0 in the following cycle.
- Halt without ImemAck has no effect.
- Simultaneous JumpReg/Jump/Branch on one commit: the priority above applies and only one target is taken.

## Test plan

- Reset then Run, ImemAck high for 4 cycles -> PCAddr 0,4,8,12 then 16; PCWrite high for 4 cycles; InstrCount=4.
- PCAddr=0x40, Branch=1, Zero=1, Imm=16'hFFFE, commit -> PCAddr=0x3C. Repeat with Zero=0 -> PCAddr=0x44.
- PCAddr=0x1000_0010, Jump=1, JumpTarget=26'h0000100 -> 0x1000_0400. Same commit with JumpReg=1, RegData=0x2003 -> 0x2000 and AlignErr pulse.
- ImemAck low for 3 cycles in FETCH -> PCAddr, InstrCount hold; ImemReq stays 1; no PCWrite.
- Halt=1 on a commit at PCAddr=0x8 -> PCAddr=0xC, Halted=1, ImemReq=0. Run=1 with Halt=0 -> FETCH resumes at 0xC.
- Reset pulled low mid-FETCH with PCAddr=0x24, InstrCount=9 -> all outputs at reset values immediately, without waiting for a clock edge. Separately, PCAddr=0xFFFF_FFFC with a sequential commit -> PCAddr=0.
